store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer between the core's data port and a single-ported backing memory.
// Stores are queued and drained in order; loads hit the youngest buffered store or go to memory first.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        empty
);

   // state     | meaning
   // IDLE      | no memory request; pick a load miss first, else drain a store
   // WRITE     | writing head entry to memory, pop on mem_ack
   // READ      | reading load miss address from memory, latch on mem_ack
   // READ_DONE | one cycle delivering rd_reg to the core

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      READ_DONE
   } state_t;

   state_t state, state_nxt;

   logic [DEPTH-1:0] valid;
   logic [29:0]      addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [PW:0]      count;
   logic [31:0]      rd_reg;

   logic        full;
   logic        push;
   logic        pop;
   logic        hit;
   logic        miss;
   logic [31:0] hit_data;

   logic unused_adr_lsb;
   assign unused_adr_lsb = ^DataAdr[1:0];

   // full comes from the registered count, so a same-cycle pop never frees a slot early
   assign full = (count == (PW+1)'(DEPTH));
   assign push = MemWrite && !full;
   assign pop  = (state == WRITE) && mem_ack;
   assign miss = MemRead && !hit;

   // Walk from oldest to youngest so the last match wins.
   always_comb begin : hit_search
      logic [PW-1:0] idx;
      idx      = '0;
      hit      = 1'b0;
      hit_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (valid[idx] && (addr_q[idx] == DataAdr[31:2])) begin
            hit      = 1'b1;
            hit_data = data_q[idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid  <= '0;
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         rd_reg <= '0;
      end else begin
         if (push) begin
            valid[tail] <= 1'b1;
            tail        <= tail + PW'(1);
         end
         if (pop) begin
            valid[head] <= 1'b0;
            head        <= head + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
         if ((state == READ) && mem_ack) begin
            rd_reg <= mem_rdata;
         end
      end
   end

   // Payload storage carries no reset; valid bits qualify it.
   always_ff @(posedge clk) begin
      if (reset && push) begin
         addr_q[tail] <= DataAdr[31:2];
         data_q[tail] <= WriteData;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (miss) begin
               state_nxt = READ;
            end else if (count != '0) begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            if (mem_ack) begin
               state_nxt = IDLE;
            end
         end
         READ: begin
            if (mem_ack) begin
               state_nxt = READ_DONE;
            end
         end
         READ_DONE: state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Outputs are gated by reset so nothing leaks out while reset is held low.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      ReadData  = '0;
      Stall     = 1'b0;
      empty     = 1'b1;
      if (reset) begin
         case (state)
            WRITE: begin
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = {addr_q[head], 2'b00};
               mem_wdata = data_q[head];
            end
            READ: begin
               mem_req  = 1'b1;
               mem_addr = {DataAdr[31:2], 2'b00};
            end
            default: begin
               mem_req = 1'b0;
            end
         endcase
         if (MemRead) begin
            if (state == READ_DONE) begin
               ReadData = rd_reg;
            end else if (hit) begin
               ReadData = hit_data;
            end
         end
         Stall = (MemWrite && full) || (miss && (state != READ_DONE));
         empty = (count == '0);
      end
   end

endmodule
